stage_event_logger: RTL and testbench
=====================================

STAGE_EVENT_LOGGER -- requirements
Module: stage_event_logger

Interface
REQ-001 SHALL have parameter NUM_EV, default 8: number of event channels (fixed at 8; channel id is 3 bits).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries (power of two).
REQ-003 SHALL have parameter TS_WIDTH, default 29: timestamp width, so that 3 + TS_WIDTH = 32.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable_i  in  1  when high, the timestamp counter runs and edges are captured.
REQ-007 clear_i  in  1  synchronous clear of pending entries, the FIFO and the overflow counter; the timestamp counter is not cleared.
REQ-008 ev_i  in  NUM_EV  level flags, ordered spmm_vld, spmm_rdy, dmvm_vld, dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy (bit 7 .. bit 0).
REQ-009 out_data_o  out  32  {ch_id[2:0], timestamp[TS_WIDTH-1:0]}.
REQ-010 out_vld_o  out  1  out_data_o is valid.
REQ-011 out_rdy_i  in  1  consumer accepts the word.
REQ-012 fifo_cnt_o  out  4  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 ovf_cnt_o  out  16  dropped-event count; saturates at 16'hFFFF.

Function
REQ-014 ts_cnt SHALL increment by 1 each cycle while enable_i is high, SHALL hold otherwise, and SHALL wrap from 2^TS_WIDTH-1 to 0.
REQ-015 SHALL register ev_i into ev_prev every cycle; rise[k] = ev_i[k] & ~ev_prev[k] & enable_i.
REQ-016 On rise[k] with pend[k] low, the block SHALL set pend[k] and latch ts_k = ts_cnt as it stands in the rise cycle.
REQ-017 On rise[k] with pend[k] high, the block SHALL keep pend[k] and ts_k unchanged and SHALL increment ovf_cnt_o by 1 for each such channel in that cycle, saturating.
REQ-018 Each cycle the arbiter SHALL select the lowest-index k with pend[k] high, and SHALL push {k, ts_k} only when fifo_cnt_o < FIFO_DEPTH.
REQ-019 A push SHALL clear pend[k] in the same cycle; a rise on the same k in that cycle SHALL re-set pend[k] with the new ts_k and SHALL NOT count as overflow.
REQ-020 Push is decided on the pre-pop count: when full, no push occurs even if a pop happens in the same cycle.
REQ-021 The FIFO SHALL be registered first-word-fall-through: a pushed entry appears on out_data_o/out_vld_o the cycle after the push when the FIFO was empty.
REQ-022 Minimum latency SHALL be 2 cycles: rise at cycle N, push at N+1, out_vld_o high at N+2.
REQ-023 Pop SHALL occur when out_vld_o & out_rdy_i; while out_vld_o is high and out_rdy_i is low, out_data_o SHALL hold stable.
REQ-024 Simultaneous push and pop SHALL leave fifo_cnt_o unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 clear_i SHALL take priority over capture, push and pop in its cycle, and SHALL set pend=0, fifo_cnt_o=0, out_vld_o=0 and ovf_cnt_o=0 on the next cycle; ev_prev still updates.
REQ-026 enable_i low SHALL block new captures only; pending entries SHALL still drain to the FIFO and the FIFO SHALL still drain to the output.

Reset
REQ-027 rst SHALL set ts_cnt=0, ev_prev=0, pend=0, pointers=0, fifo_cnt_o=0, out_vld_o=0, out_data_o=0 and ovf_cnt_o=0.
REQ-028 rst SHALL take priority over clear_i and all other inputs, and SHALL discard an in-flight word mid-handshake.
REQ-029 Because ev_prev=0, a channel held high through the release of reset SHALL produce a rise in the first enabled cycle.

Verification
REQ-030 Single event: reset, enable_i=1, out_rdy_i=1, raise ev_i[4] when ts_cnt=10 -> out_data_o={3'd4, 29'd10} with out_vld_o high exactly 2 cycles later, for 1 cycle.
REQ-031 Simultaneous events: raise ev_i=8'hFF in one cycle at ts_cnt=5 -> 8 words in channel order 0..7, all with timestamp 5, ovf_cnt_o=0.
REQ-032 Backpressure: out_rdy_i=0, 10 distinct rises on channel 0, each separated by 2 low cycles -> fifo_cnt_o=8, one entry pending, further rises counted (ovf_cnt_o>=1); release out_rdy_i -> words in order, timestamps ascending.
REQ-033 Overflow saturation: with the FIFO full and the pend bit set, 70000 rises on channel 1 -> ovf_cnt_o=16'hFFFF; assert clear_i -> next cycle ovf_cnt_o=0, fifo_cnt_o=0.
REQ-034 Timestamp wrap: force ts_cnt near 2^29-1 (or run with TS_WIDTH=4), rise at 15 then 1 -> timestamps 15 then 1, with no glitch on out_vld_o.
REQ-035 Reset mid-handshake: out_vld_o=1, out_rdy_i=0, assert rst for 1 cycle -> next cycle out_vld_o=0, fifo_cnt_o=0, ts_cnt=0; ev_i held high -> a new word with timestamp 0.

Source files
------------

// File: rtl/stage_event_logger.sv
// Stage event logger: captures rising edges on NUM_EV level flags, timestamps
// them, arbitrates lowest channel first into a small FWFT FIFO, and counts
// edges lost because a channel already had an unsent capture.
module stage_event_logger #(
  parameter int NUM_EV     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 29
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [NUM_EV-1:0]           ev_i,
  output logic [TS_WIDTH+2:0]         out_data_o,
  output logic                        out_vld_o,
  input  logic                        out_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic [15:0]                 ovf_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TS_WIDTH + 3;
  localparam int IW = $clog2(NUM_EV + 1);

  logic [TS_WIDTH-1:0] ts_cnt_reg;
  logic [NUM_EV-1:0]   ev_prev_reg;
  logic [NUM_EV-1:0]   pend_vec;
  logic [TS_WIDTH-1:0] ts_k_vec [NUM_EV];
  logic [NUM_EV-1:0]   rise;
  logic [NUM_EV-1:0]   push_oh;
  logic [2:0]          sel_idx;
  logic                sel_vld;
  logic                push;
  logic                pop;
  logic                head_bypass;
  logic [DW-1:0]       push_data;

  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW-1:0]       rd_ptr_next;
  logic [CW-1:0]       cnt_reg;
  logic [CW-1:0]       cnt_next;
  logic                vld_reg;
  logic [DW-1:0]       data_reg;

  logic [15:0]         ovf_reg;
  logic [IW-1:0]       ovf_inc;
  logic [16:0]         ovf_sum;

  // Free-running timestamp, advances only while enabled; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_reg <= '0;
    end else if (enable_i) begin
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
    end
  end

  // Previous-cycle event levels for edge detection; keeps updating during clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_prev_reg <= '0;
    end else begin
      ev_prev_reg <= ev_i;
    end
  end

  // Clear suppresses capture in its cycle.
  assign rise = ev_i & ~ev_prev_reg & {NUM_EV{enable_i & ~clear_i}};

  // Lowest-index pending channel wins; push only when the pre-pop count has room.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NUM_EV - 1; k >= 0; k--) begin
      if (pend_vec[k]) begin
        sel_vld = 1'b1;
        sel_idx = 3'(k);
      end
    end
    push      = sel_vld & ~clear_i & (cnt_reg < CW'(FIFO_DEPTH));
    push_oh   = '0;
    if (push) begin
      push_oh[sel_idx] = 1'b1;
    end
    push_data = {sel_idx, ts_k_vec[sel_idx]};
  end

  // Per-channel pending flag and captured timestamp. A rise in the same cycle
  // as this channel's push re-arms it with the fresh timestamp.
  generate
    for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_ch
      logic                pend_reg;
      logic [TS_WIDTH-1:0] ts_k_reg;

      // Capture/arm, or retire on push.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
          ts_k_reg <= '0;
        end else if (clear_i) begin
          pend_reg <= 1'b0;
        end else if (rise[gi] && (!pend_reg || push_oh[gi])) begin
          pend_reg <= 1'b1;
          ts_k_reg <= ts_cnt_reg;
        end else if (push_oh[gi]) begin
          pend_reg <= 1'b0;
        end
      end

      assign pend_vec[gi] = pend_reg;
      assign ts_k_vec[gi] = ts_k_reg;
    end
  endgenerate

  // Lost edges this cycle: rises on channels still holding an unsent capture.
  always_comb begin
    ovf_inc = '0;
    for (int k = 0; k < NUM_EV; k++) begin
      ovf_inc = ovf_inc + IW'(rise[k] & pend_vec[k] & ~push_oh[k]);
    end
    ovf_sum = {1'b0, ovf_reg} + 17'(ovf_inc);
  end

  // Saturating overflow counter.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ovf_reg <= '0;
    end else if (ovf_sum[16]) begin
      ovf_reg <= 16'hFFFF;
    end else begin
      ovf_reg <= ovf_sum[15:0];
    end
  end

  // FIFO bookkeeping. When the pushed word becomes the head (queue empty after
  // any pop), it bypasses the RAM straight into the output register.
  assign pop         = vld_reg & out_rdy_i & ~clear_i;
  assign cnt_next    = cnt_reg + CW'(push) - CW'(pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  assign head_bypass = push & (cnt_reg == CW'(pop));

  // Storage array, write port only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      vld_reg    <= 1'b0;
      data_reg   <= '0;
    end else if (clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      vld_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      vld_reg    <= (cnt_next != '0);
      if (cnt_next != '0) begin
        data_reg <= head_bypass ? push_data : mem[rd_ptr_next];
      end
    end
  end

  assign out_data_o = data_reg;
  assign out_vld_o  = vld_reg;
  assign fifo_cnt_o = cnt_reg;
  assign ovf_cnt_o  = ovf_reg;

endmodule

// File: tb/tb_stage_event_logger.sv
// Self-checking bench for stage_event_logger: table vectors, hand sequences
// for backpressure, saturation, wrap and reset, then random traffic against a
// queue-based reference model.
module tb_stage_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        clear_i;
  logic [7:0]  ev_i;
  logic [31:0] out_data_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic [3:0]  fifo_cnt_o;
  logic [15:0] ovf_cnt_o;

  // Narrow-timestamp instance used for the wrap sequence.
  logic [7:0]  ev_w;
  logic [6:0]  w_data;
  logic        w_vld;
  logic [3:0]  w_cnt;
  logic [15:0] w_ovf;

  int n_vec = 0;
  int n_bad = 0;
  bit use_model = 1'b0;

  always #5 clk = ~clk;

  stage_event_logger dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .ev_i(ev_i),
    .out_data_o(out_data_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .fifo_cnt_o(fifo_cnt_o), .ovf_cnt_o(ovf_cnt_o)
  );

  stage_event_logger #(.TS_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .enable_i(enable_i), .clear_i(clear_i), .ev_i(ev_w),
    .out_data_o(w_data), .out_vld_o(w_vld), .out_rdy_i(out_rdy_i),
    .fifo_cnt_o(w_cnt), .ovf_cnt_o(w_ovf)
  );

  // Reference model: pending bits + captured timestamps + a word queue.
  bit [7:0]    m_prev;
  bit [7:0]    m_pend;
  bit [28:0]   m_ts;
  bit [28:0]   m_tsk [8];
  bit [31:0]   m_q [$];
  int          m_ovf;

  task automatic model_step();
    bit [7:0] rise;
    bit       full;
    bit       found;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_ts = '0; m_q.delete(); m_ovf = 0;
      return;
    end
    if (clear_i) begin
      m_pend = '0; m_q.delete(); m_ovf = 0;
    end else begin
      rise  = ev_i & ~m_prev & {8{enable_i}};
      full  = (m_q.size() == 8);
      if (m_q.size() != 0 && out_rdy_i) void'(m_q.pop_front());
      found = 1'b0;
      if (!full) begin
        for (int k = 0; k < 8; k++) begin
          if (!found && m_pend[k]) begin
            found     = 1'b1;
            m_pend[k] = 1'b0;
            m_q.push_back({3'(k), m_tsk[k]});
          end
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (rise[k]) begin
          if (m_pend[k]) begin
            if (m_ovf < 65535) m_ovf++;
          end else begin
            m_pend[k] = 1'b1;
            m_tsk[k]  = m_ts;
          end
        end
      end
    end
    if (enable_i) m_ts = m_ts + 29'd1;
    m_prev = ev_i;
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  ev;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;

    // Table: single event on ch4 at ts=10, then all channels at ts=14.
    for (int i = 0; i < 24; i++) tbl[i] = '{8'h00, 1'b1, 1'b0, 32'h0, 4'd0};
    tbl[10] = '{8'h10, 1'b1, 1'b0, 32'h0, 4'd0};
    tbl[11] = '{8'h10, 1'b1, 1'b1, {3'd4, 29'd10}, 4'd1};
    tbl[12] = '{8'h10, 1'b1, 1'b0, 32'h0, 4'd0};
    tbl[14] = '{8'hFF, 1'b1, 1'b0, 32'h0, 4'd0};
    for (int k = 0; k < 8; k++) tbl[15+k] = '{8'hFF, 1'b1, 1'b1, {3'(k), 29'd14}, 4'd1};

    rst = 1'b1; enable_i = 1'b0; clear_i = 1'b0; out_rdy_i = 1'b0;
    ev_i = '0; ev_w = '0;
    tick(); tick();
    chk("rst_vld", 32'(out_vld_o), 32'd0);
    chk("rst_data", out_data_o, 32'd0);
    chk("rst_cnt", 32'(fifo_cnt_o), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt_o), 32'd0);
    chk("rst_w_vld", 32'(w_vld), 32'd0);
    rst = 1'b0;
    enable_i = 1'b1;

    for (int i = 0; i < 24; i++) begin
      ev_i = tbl[i].ev;
      out_rdy_i = tbl[i].rdy;
      tick();
      $display("vec %0d ev=%h vld=%b data=%h cnt=%0d", i, ev_i, out_vld_o, out_data_o, fifo_cnt_o);
      chk($sformatf("tbl%0d_vld", i), 32'(out_vld_o), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_cnt", i), 32'(fifo_cnt_o), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf_cnt_o), 32'd0);
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_data", i), out_data_o, tbl[i].exp_data);
    end

    // Timestamp wrap on the 4-bit instance: rises at ts 15 (ch0) and 1 (ch5).
    ev_i = '0; out_rdy_i = 1'b1;
    rst_pulse();
    for (int j = 0; j < 20; j++) begin
      ev_w = (j == 15) ? 8'h01 : (j == 17) ? 8'h20 : 8'h00;
      tick();
      $display("wrap %0d vld=%b data=%h", j, w_vld, w_data);
      chk($sformatf("wrap%0d_vld", j), 32'(w_vld), (j == 16 || j == 18) ? 32'd1 : 32'd0);
      if (j == 16) chk("wrap_data15", 32'(w_data), 32'({3'd0, 4'd15}));
      if (j == 18) chk("wrap_data1", 32'(w_data), 32'({3'd5, 4'd1}));
    end
    ev_w = '0;

    // Backpressure: 10 rises on ch0 every 3 cycles with the consumer stalled.
    out_rdy_i = 1'b0;
    rst_pulse();
    for (int j = 0; j < 30; j++) begin
      ev_i = (j % 3 == 0) ? 8'h01 : 8'h00;
      tick();
    end
    ev_i = '0;
    $display("bp stalled cnt=%0d ovf=%0d", fifo_cnt_o, ovf_cnt_o);
    chk("bp_cnt", 32'(fifo_cnt_o), 32'd8);
    chk("bp_ovf", 32'(ovf_cnt_o), 32'd1);
    chk("bp_vld", 32'(out_vld_o), 32'd1);
    chk("bp_hold", out_data_o, 32'd0);
    out_rdy_i = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_vld_o && got < 9) begin
        $display("bp word %0d data=%h", got, out_data_o);
        chk($sformatf("bp_word%0d", got), out_data_o, {3'd0, 29'(3 * got)});
        got++;
      end
      tick();
    end
    chk("bp_words", 32'(got), 32'd9);
    chk("bp_ovf_after", 32'(ovf_cnt_o), 32'd1);

    // Overflow saturation with all channels pending and the FIFO full.
    out_rdy_i = 1'b0;
    rst_pulse();
    ev_i = 8'hFF; tick();
    ev_i = 8'h00;
    for (int j = 0; j < 9; j++) tick();
    chk("sat_fill_cnt", 32'(fifo_cnt_o), 32'd8);
    ev_i = 8'hFF; tick();
    ev_i = 8'h00; tick();
    chk("sat_arm_ovf", 32'(ovf_cnt_o), 32'd0);
    for (int j = 0; j < 100; j++) begin
      ev_i = 8'hFF; tick();
      ev_i = 8'h00; tick();
    end
    $display("sat partial ovf=%0d", ovf_cnt_o);
    chk("sat_ovf800", 32'(ovf_cnt_o), 32'd800);
    for (int j = 0; j < 8100; j++) begin
      ev_i = 8'hFF; tick();
      ev_i = 8'h00; tick();
    end
    $display("sat final ovf=%h", ovf_cnt_o);
    chk("sat_ovf_max", 32'(ovf_cnt_o), 32'hFFFF);
    chk("sat_cnt", 32'(fifo_cnt_o), 32'd8);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clr_ovf", 32'(ovf_cnt_o), 32'd0);
    chk("clr_cnt", 32'(fifo_cnt_o), 32'd0);
    chk("clr_vld", 32'(out_vld_o), 32'd0);
    tick();
    chk("clr_nopend", 32'(fifo_cnt_o), 32'd0);

    // Reset while a word waits on a stalled consumer; ch2 held high across it.
    rst_pulse();
    for (int j = 0; j < 5; j++) tick();
    ev_i = 8'h04;
    tick(); tick();
    chk("mh_vld", 32'(out_vld_o), 32'd1);
    chk("mh_data", out_data_o, {3'd2, 29'd5});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mh_rst_vld", 32'(out_vld_o), 32'd0);
    chk("mh_rst_cnt", 32'(fifo_cnt_o), 32'd0);
    tick();
    chk("mh_rise_vld", 32'(out_vld_o), 32'd0);
    tick();
    $display("mh new word vld=%b data=%h", out_vld_o, out_data_o);
    chk("mh_new_vld", 32'(out_vld_o), 32'd1);
    chk("mh_new_data", out_data_o, {3'd2, 29'd0});

    // Random traffic against the model.
    use_model = 1'b1;
    ev_i = '0;
    rst_pulse();
    for (int c = 0; c < 2500; c++) begin
      ev_i      = ev_i ^ 8'($urandom & $urandom & $urandom);
      enable_i  = ($urandom_range(0, 9) != 0);
      if ((c / 150) % 2 == 1) out_rdy_i = ($urandom_range(0, 3) == 0);
      else                    out_rdy_i = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      if (out_vld_o && out_rdy_i && !clear_i && !rst)
        $display("rnd word ch=%0d ts=%0d", out_data_o[31:29], out_data_o[28:0]);
      tick();
      chk("rnd_vld", 32'(out_vld_o), (m_q.size() != 0) ? 32'd1 : 32'd0);
      chk("rnd_cnt", 32'(fifo_cnt_o), 32'(m_q.size()));
      chk("rnd_ovf", 32'(ovf_cnt_o), 32'(m_ovf));
      if (m_q.size() != 0) chk("rnd_data", out_data_o, m_q[0]);
    end
    rst = 1'b0;
    clear_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
